// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests, with the fetch-starvation counter.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en,
  input  logic   if_req,
  input  logic   dm_req,
  output logic   req_any,
  output owner_t winner
);

  localparam int unsigned  SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  assign req_any = if_req | dm_req;

  // Data normally wins; fetch takes the slot once it has waited out STARVE_MAX data grants.
  always_comb begin
    winner = OWN_DM;
    if (if_req && (!dm_req || (starve_cnt == SMAX))) begin
      winner = OWN_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!if_req || (winner == OWN_IF)) begin
        starve_cnt <= '0;
      end else if (dm_req && (starve_cnt != SMAX)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: IF fetch and MEM load/store share one memory,
// one outstanding access at a time, with a response watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                err
);

  localparam int unsigned   WW      = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  arb_state_t    state, state_next;
  owner_t        owner;
  owner_t        winner;
  logic          req_any;
  logic [WW-1:0] wd_cnt;
  logic          issue;
  logic          rsp_fire;
  logic          wd_fire;
  logic          stray;
  logic          rsp_any;
  logic [DATA_W-1:0] rsp_data;

  mem_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state == IDLE),
    .if_req (if_req),
    .dm_req (dm_req),
    .req_any(req_any),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A real response takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    rsp_fire   = 1'b0;
    wd_fire    = 1'b0;
    stray      = 1'b0;
    case (state)
      IDLE: begin
        stray = mem_rvalid;
        if (req_any) begin
          issue      = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          wd_fire    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      owner     <= OWN_IF;
      wd_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      if_gnt  <= issue && (winner == OWN_IF);
      dm_gnt  <= issue && (winner == OWN_DM);
      mem_req <= issue;
      if (issue) begin
        owner  <= winner;
        wd_cnt <= '0;
        if (winner == OWN_DM) begin
          mem_we    <= dm_we;
          mem_addr  <= dm_addr;
          mem_wdata <= dm_wdata;
          mem_be    <= dm_be;
        end else begin
          mem_we    <= 1'b0;
          mem_addr  <= if_addr;
          mem_wdata <= '0;
          mem_be    <= '0;
        end
      end else if (state == WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_fire || stray) begin
        err <= 1'b1;
      end
    end
  end

  // Response routing is combinational so data lands in the same cycle as mem_rvalid.
  always_comb begin
    rsp_any   = (rsp_fire || wd_fire) && !rst;
    rsp_data  = rsp_fire ? mem_rdata : '0;
    if_rvalid = rsp_any && (owner == OWN_IF);
    dm_rvalid = rsp_any && (owner == OWN_DM);
    if_rdata  = if_rvalid ? rsp_data : '0;
    dm_rdata  = dm_rvalid ? rsp_data : '0;
  end

  assign busy = (state == WAIT);

endmodule
